// File: rtl/mem_share_arbiter.sv
// mem_share_arbiter: shares the unified MIPS instruction/data memory between
// the multicycle core and an external requester (loader / debug port).
// The core has no handshake, so it is frozen with core_stall while the
// external side owns memory. External grants are bounded to MAX_BURST
// accesses, and the core is guaranteed MIN_CORE cycles between grants.
// Optional feature: define ARB_EXT_LOCK_EN to add the ext_lock input, which
// lets a bulk loader hold the grant past MAX_BURST.

module mem_share_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter int MAX_BURST = 4,
  parameter int MIN_CORE  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] core_addr,
  input  logic [BUS_WIDTH-1:0] core_wd,
  input  logic                 core_we,
  output logic [BUS_WIDTH-1:0] core_rd,
  output logic                 core_stall,
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [BUS_WIDTH-1:0] ext_addr,
  input  logic [BUS_WIDTH-1:0] ext_wd,
`ifdef ARB_EXT_LOCK_EN
  input  logic                 ext_lock,
`endif
  output logic                 ext_ack,
  output logic [BUS_WIDTH-1:0] ext_rdata,
  output logic                 ext_rvalid,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wd,
  output logic                 mem_we,
  input  logic [BUS_WIDTH-1:0] mem_rd
);

  // Burst counter must reach MAX_BURST (saturation point under lock).
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(MIN_CORE + 1);

  typedef enum logic {
    CORE = 1'b0,
    EXT  = 1'b1
  } state_t;

  state_t          state;
  logic [BW-1:0]   burst_cnt;
  logic [CW-1:0]   core_cnt;
  logic            lock_hold;
  logic            burst_at_limit;
  logic            core_quota_met;

`ifdef ARB_EXT_LOCK_EN
  assign lock_hold = ext_lock;
`else
  assign lock_hold = 1'b0;
`endif

  // >= rather than == so that dropping ext_lock after the counter has
  // saturated still ends the grant on the next ack.
  assign burst_at_limit = (burst_cnt >= BW'(MAX_BURST - 1));
  assign core_quota_met = (core_cnt >= CW'(MIN_CORE));

  // Memory port mux and handshake decode, driven purely by the owner state.
  always_comb begin
    core_stall = (state == EXT);
    core_rd    = mem_rd;
    mem_addr   = core_addr;
    mem_wd     = core_wd;
    mem_we     = core_we;
    ext_ack    = 1'b0;
    if (state == EXT) begin
      mem_addr = ext_addr;
      mem_wd   = ext_wd;
      mem_we   = ext_req & ext_we;
      ext_ack  = ext_req;
    end
  end

  // Ownership FSM with burst / core-time counters and the external read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CORE;
      burst_cnt  <= '0;
      core_cnt   <= CW'(MIN_CORE);
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      case (state)
        CORE: begin
          ext_rvalid <= 1'b0;
          if (!core_quota_met) begin
            core_cnt <= core_cnt + CW'(1);
          end
          if (ext_req && core_quota_met) begin
            state     <= EXT;
            burst_cnt <= '0;
          end
        end
        EXT: begin
          if (!ext_req) begin
            state      <= CORE;
            core_cnt   <= '0;
            ext_rvalid <= 1'b0;
          end else begin
            if (burst_cnt != BW'(MAX_BURST)) begin
              burst_cnt <= burst_cnt + BW'(1);
            end
            if (!ext_we) begin
              ext_rdata  <= mem_rd;
              ext_rvalid <= 1'b1;
            end else begin
              ext_rvalid <= 1'b0;
            end
            if (burst_at_limit && !lock_hold) begin
              state    <= CORE;
              core_cnt <= '0;
            end
          end
        end
        default: begin
          state <= CORE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_share_arbiter.sv
// tb_mem_share_arbiter: directed, table-driven bench for mem_share_arbiter
// with a small word-addressed memory model behind the mem_* port.
// Covers ARB_EXT_LOCK_EN when that macro is defined for the build.

module tb_mem_share_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic        core_we;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wd;
`ifdef ARB_EXT_LOCK_EN
  logic        ext_lock;
`endif
  logic        ext_ack;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic        init_mem;
  logic [31:0] mem [0:63];

  int n_checks;
  int n_fail;

  mem_share_arbiter #(
    .BUS_WIDTH(32),
    .MAX_BURST(4),
    .MIN_CORE (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core_addr (core_addr),
    .core_wd   (core_wd),
    .core_we   (core_we),
    .core_rd   (core_rd),
    .core_stall(core_stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wd    (ext_wd),
`ifdef ARB_EXT_LOCK_EN
    .ext_lock  (ext_lock),
`endif
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata),
    .ext_rvalid(ext_rvalid),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, synchronous write, preloaded while init_mem is high.
  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
      mem[4]  <= 32'hDEADBEEF;
      mem[16] <= 32'h11111111;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wd;
    end
  end

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic        cwe;
    logic [31:0] caddr;
    logic [31:0] cwd;
    logic        e_stall;
    logic        e_ack;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic [31:0] e_mem40;
  } vec_t;

  vec_t vecs [0:18];

  function automatic vec_t mk(input logic req, input logic we, input logic [31:0] eaddr,
                              input logic [31:0] ewd, input logic cwe, input logic [31:0] caddr,
                              input logic [31:0] cwd, input logic e_stall, input logic e_ack,
                              input logic e_mwe, input logic [31:0] e_maddr, input logic e_rvalid,
                              input logic [31:0] e_rdata, input logic [31:0] e_mem40);
    vec_t v;
    v.req = req; v.we = we; v.eaddr = eaddr; v.ewd = ewd;
    v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.e_stall = e_stall; v.e_ack = e_ack; v.e_mwe = e_mwe; v.e_maddr = e_maddr;
    v.e_rvalid = e_rvalid; v.e_rdata = e_rdata; v.e_mem40 = e_mem40;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    ext_req   = v.req;
    ext_we    = v.we;
    ext_addr  = v.eaddr;
    ext_wd    = v.ewd;
    core_we   = v.cwe;
    core_addr = v.caddr;
    core_wd   = v.cwd;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    init_mem  = 1'b1;
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = 32'h0;
    ext_wd    = 32'h0;
    core_we   = 1'b0;
    core_addr = 32'h40;
    core_wd   = 32'h0;
`ifdef ARB_EXT_LOCK_EN
    ext_lock  = 1'b0;
`endif

    // Write burst, core window, read, core_we during grant, release by drop, re-grant.
    vecs[0]  = mk(1, 1, 32'h00, 32'h20080005, 0, 32'h40, 32'h0,        0, 0, 0, 32'h40, 0, 32'h0,        32'h11111111);
    vecs[1]  = mk(1, 1, 32'h00, 32'h20080005, 0, 32'h40, 32'h0,        1, 1, 1, 32'h00, 0, 32'h0,        32'h11111111);
    vecs[2]  = mk(1, 1, 32'h00, 32'h20080005, 0, 32'h40, 32'h0,        1, 1, 1, 32'h00, 0, 32'h0,        32'h11111111);
    vecs[3]  = mk(1, 1, 32'h00, 32'h20080005, 0, 32'h40, 32'h0,        1, 1, 1, 32'h00, 0, 32'h0,        32'h11111111);
    vecs[4]  = mk(1, 1, 32'h00, 32'h20080005, 0, 32'h40, 32'h0,        1, 1, 1, 32'h00, 0, 32'h0,        32'h11111111);
    vecs[5]  = mk(1, 1, 32'h00, 32'h20080005, 0, 32'h40, 32'h0,        0, 0, 0, 32'h40, 0, 32'h0,        32'h11111111);
    vecs[6]  = mk(1, 1, 32'h00, 32'h20080005, 0, 32'h40, 32'h0,        0, 0, 0, 32'h40, 0, 32'h0,        32'h11111111);
    vecs[7]  = mk(1, 1, 32'h00, 32'h20080005, 1, 32'h44, 32'h77777777, 0, 0, 1, 32'h44, 0, 32'h0,        32'h11111111);
    vecs[8]  = mk(1, 0, 32'h10, 32'h0,        1, 32'h40, 32'h99999999, 1, 1, 0, 32'h10, 0, 32'h0,        32'h11111111);
    vecs[9]  = mk(1, 1, 32'h20, 32'hCAFEF00D, 1, 32'h40, 32'h99999999, 1, 1, 1, 32'h20, 1, 32'hDEADBEEF, 32'h11111111);
    vecs[10] = mk(0, 1, 32'h20, 32'hCAFEF00D, 1, 32'h40, 32'h99999999, 1, 0, 0, 32'h20, 0, 32'hDEADBEEF, 32'h11111111);
    vecs[11] = mk(0, 0, 32'h00, 32'h0,        1, 32'h40, 32'h99999999, 0, 0, 1, 32'h40, 0, 32'hDEADBEEF, 32'h11111111);
    vecs[12] = mk(1, 1, 32'h30, 32'h12345678, 0, 32'h40, 32'h0,        0, 0, 0, 32'h40, 0, 32'hDEADBEEF, 32'h99999999);
    vecs[13] = mk(1, 1, 32'h30, 32'h12345678, 0, 32'h40, 32'h0,        0, 0, 0, 32'h40, 0, 32'hDEADBEEF, 32'h99999999);
    vecs[14] = mk(1, 1, 32'h30, 32'h12345678, 0, 32'h40, 32'h0,        1, 1, 1, 32'h30, 0, 32'hDEADBEEF, 32'h99999999);
    vecs[15] = mk(1, 1, 32'h30, 32'h12345678, 0, 32'h40, 32'h0,        1, 1, 1, 32'h30, 0, 32'hDEADBEEF, 32'h99999999);
    vecs[16] = mk(1, 1, 32'h30, 32'h12345678, 0, 32'h40, 32'h0,        1, 1, 1, 32'h30, 0, 32'hDEADBEEF, 32'h99999999);
    vecs[17] = mk(1, 1, 32'h30, 32'h12345678, 0, 32'h40, 32'h0,        1, 1, 1, 32'h30, 0, 32'hDEADBEEF, 32'h99999999);
    vecs[18] = mk(0, 0, 32'h00, 32'h0,        0, 32'h40, 32'h0,        0, 0, 0, 32'h40, 0, 32'hDEADBEEF, 32'h99999999);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_output("reset core_stall", {31'h0, core_stall}, 32'h0);
    check_output("reset ext_ack",    {31'h0, ext_ack},    32'h0);
    check_output("reset ext_rvalid", {31'h0, ext_rvalid}, 32'h0);
    check_output("reset ext_rdata",  ext_rdata,           32'h0);
    check_output("reset mem_addr",   mem_addr,            32'h40);
    @(negedge clk);
    rst      = 1'b1;
    init_mem = 1'b0;

    // Table-driven cycles.
    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d core_stall", i), {31'h0, core_stall}, {31'h0, vecs[i].e_stall});
      check_output($sformatf("v%0d ext_ack", i),    {31'h0, ext_ack},    {31'h0, vecs[i].e_ack});
      check_output($sformatf("v%0d mem_we", i),     {31'h0, mem_we},     {31'h0, vecs[i].e_mwe});
      check_output($sformatf("v%0d mem_addr", i),   mem_addr,            vecs[i].e_maddr);
      check_output($sformatf("v%0d ext_rvalid", i), {31'h0, ext_rvalid}, {31'h0, vecs[i].e_rvalid});
      check_output($sformatf("v%0d ext_rdata", i),  ext_rdata,           vecs[i].e_rdata);
      check_output($sformatf("v%0d mem40", i),      mem[16],             vecs[i].e_mem40);
      check_output($sformatf("v%0d core_rd", i),    core_rd,             mem[vecs[i].e_maddr[7:2]]);
      @(negedge clk);
    end

    check_output("mem[0x00]", mem[0],  32'h20080005);
    check_output("mem[0x20]", mem[8],  32'hCAFEF00D);
    check_output("mem[0x44]", mem[17], 32'h77777777);
    check_output("mem[0x40]", mem[16], 32'h99999999);
    check_output("mem[0x30]", mem[12], 32'h12345678);

    // Asynchronous reset in the middle of a read burst.
    ext_req  = 1'b1;
    ext_we   = 1'b0;
    ext_addr = 32'h10;
    core_we  = 1'b0;
    for (int t = 0; t < 8; t++) begin
      #1;
      if (core_stall) break;
      @(negedge clk);
    end
    check_output("rstseq grant stall", {31'h0, core_stall}, 32'h1);
    check_output("rstseq grant ack",   {31'h0, ext_ack},    32'h1);
    @(negedge clk);
    #1;
    check_output("rstseq rvalid",      {31'h0, ext_rvalid}, 32'h1);
    check_output("rstseq rdata",       ext_rdata,           32'hDEADBEEF);
    check_output("rstseq mid stall",   {31'h0, core_stall}, 32'h1);
    rst = 1'b0;
    #1;
    check_output("rstseq stall",       {31'h0, core_stall}, 32'h0);
    check_output("rstseq ack",         {31'h0, ext_ack},    32'h0);
    check_output("rstseq rvalid clr",  {31'h0, ext_rvalid}, 32'h0);
    check_output("rstseq mem_addr",    mem_addr,            32'h40);
    @(negedge clk);
    ext_req = 1'b0;
    rst     = 1'b1;

`ifdef ARB_EXT_LOCK_EN
    // Locked bulk load: ten writes with no core window, release after unlock.
    @(negedge clk);
    ext_lock = 1'b1;
    ext_req  = 1'b1;
    ext_we   = 1'b1;
    ext_addr = 32'h80;
    ext_wd   = 32'h1;
    #1;
    check_output("lock grant stall", {31'h0, core_stall}, 32'h0);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      ext_addr = 32'h80 + 32'(4 * j);
      ext_wd   = 32'(j + 1);
      #1;
      check_output($sformatf("lock w%0d stall", j), {31'h0, core_stall}, 32'h1);
      check_output($sformatf("lock w%0d ack", j),   {31'h0, ext_ack},    32'h1);
    end
    @(negedge clk);
    ext_lock = 1'b0;
    ext_addr = 32'hA8;
    ext_wd   = 32'hB;
    #1;
    check_output("unlock ack",   {31'h0, ext_ack},    32'h1);
    check_output("unlock stall", {31'h0, core_stall}, 32'h1);
    @(negedge clk);
    #1;
    check_output("unlock release stall", {31'h0, core_stall}, 32'h0);
    check_output("unlock release ack",   {31'h0, ext_ack},    32'h0);
    ext_req = 1'b0;
    check_output("lock mem[0xA4]", mem[41], 32'hA);
    check_output("lock mem[0xA8]", mem[42], 32'hB);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_share_arbiter.md
Name: mem_share_arbiter

Overview:
Arbitrates the single unified instruction/data memory between the multicycle MIPS core and an external requester (program loader / debug port). The core has no handshake, so the block freezes it with core_stall while the external side owns the memory. It sits between the core's address/write-data/write-enable outputs and the memory instance. A bounded-burst / minimum-core-time policy prevents either side from starving the other.

Parameters:
BUS_WIDTH, 32, width of address, write data and read data
MAX_BURST, 4, maximum consecutive external accesses per grant (>=1)
MIN_CORE, 2, minimum cycles the core owns memory between external grants (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
core_addr  in  BUS_WIDTH  core memory address
core_wd  in  BUS_WIDTH  core write data
core_we  in  1  core write enable
core_rd  out  BUS_WIDTH  read data to core (mem_rd pass-through)
core_stall  out  1  1 = core must hold all state (global enable low)
ext_req  in  1  external access request, held with addr/we/wd until ext_ack
ext_we  in  1  1 = write, 0 = read
ext_addr  in  BUS_WIDTH  external address
ext_wd  in  BUS_WIDTH  external write data
ext_ack  out  1  access performed this cycle
ext_rdata  out  BUS_WIDTH  registered read data
ext_rvalid  out  1  ext_rdata valid (one-cycle pulse, cycle after read ack)
mem_addr  out  BUS_WIDTH  to memory A
mem_wd  out  BUS_WIDTH  to memory WD
mem_we  out  1  to memory WE
mem_rd  in  BUS_WIDTH  from memory RD (combinational read)

Behaviour:
- States: CORE, EXT. Reset: state=CORE, burst_cnt=0, core_cnt=MIN_CORE (saturated, so a loader can take memory immediately after reset), ext_rdata=0, ext_rvalid=0.
- Outputs after reset: core_stall=0, ext_ack=0, mem_* follow core.
- CORE: mem_addr/mem_wd/mem_we = core_*; core_stall=0; ext_ack=0; core_cnt increments, saturating at MIN_CORE.
- CORE -> EXT when ext_req=1 and core_cnt>=MIN_CORE; the transition cycle is still a core cycle (core access completes). Clear burst_cnt.
- EXT: core_stall=1; mem_addr=ext_addr, mem_wd=ext_wd, mem_we=ext_req&ext_we; core_we ignored (no core write can reach memory while stalled); ext_ack=ext_req.
- Each ack: burst_cnt+1. On ack of a read, ext_rdata<=mem_rd, ext_rvalid<=1 next cycle; otherwise ext_rvalid<=0.
- EXT -> CORE when ext_req=0, or an ack occurs with burst_cnt==MAX_BURST-1. core_cnt cleared to 0 on entry to CORE.
- Latency: ext_req asserted in CORE with quota met -> first ack next cycle; read data one cycle after its ack.
- core_stall is a registered-state decode: asserted the cycle after the grant decision, deasserted the cycle after release.
- ext_req dropped mid-burst: release that cycle, no access, no ack.
- Simultaneous core_we and ext grant decision: core write performed (CORE cycle), external waits one cycle.
- Reset mid-burst: immediate return to CORE, stall released, rvalid cleared; in-flight external access is lost (requester must retry).
- core_rd = mem_rd always (stalled core ignores it).

Optional Feature:
ARB_EXT_LOCK_EN: adds input ext_lock (1 bit). When defined, while ext_lock=1 in EXT the MAX_BURST limit is ignored and the grant persists until ext_req=0 or ext_lock=0 (bulk program load); an ack with burst_cnt==MAX_BURST-1 releases only if ext_lock=0. burst_cnt saturates rather than wrapping. Without the macro, no ext_lock port exists and MAX_BURST always applies.

Test Plan:
- Reset, ext_req=1, we=1, addr=0x0, wd=0x20080005, held 6 cycles -> ack in cycles 1-4 after grant, then CORE for 2 cycles (core_stall=0), then re-grant; memory[0]=0x20080005.
- Read from ext_addr=0x10 holding 0xDEADBEEF -> ext_ack, next cycle ext_rvalid=1, ext_rdata=0xDEADBEEF.
- core_we=1 throughout an EXT grant with core_addr=0x40 -> mem_we only on ext writes; memory[0x40] unchanged until the core owns memory again.
- ext_req dropped after 2 acks -> core_stall falls the following cycle; burst_cnt restarts at 0 on the next grant.
- rst pulsed low during EXT -> core_stall=0, ext_rvalid=0, state=CORE immediately (asynchronous).
- ARB_EXT_LOCK_EN defined, ext_lock=1, 10 consecutive writes -> 10 consecutive acks with no core window; ext_lock=0 -> release after the next ack.
